code_dispatcher: RTL and testbench
==================================

# code_dispatcher

Sequential back end for the 4-to-2 priority encoder's code/valid output. It latches each incoming code into a pending bitmap and re-expands it to a one-hot service line. Pending lines are dispatched one at a time, highest index first, over a valid/ready handshake. An enable input gates dispatch the same way `en` gates the 2-to-4 decoder.

## Interface
- `CODE_W`, default 2: code width; line count `N = 1 << CODE_W` is a derived constant (4 by default).
- `CNT_W`, default 8: width of the drop counter and of each dispatch counter.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  code present; driven directly from encoder `valid`.
- `in_code`  in  CODE_W  encoded line index.
- `in_ready`  out  1  constant 1 after reset; codes are never back-pressured.
- `en`  in  1  dispatch enable; 0 blocks starting a new dispatch.
- `out_valid`  out  1  dispatch in flight.
- `out_onehot`  out  N  one-hot line being dispatched; all zeros when `out_valid` = 0.
- `out_ready`  in  1  consumer accepts dispatch.
- `pend`  out  N  pending bitmap.
- `drop_cnt`  out  CNT_W  count of codes merged into an already-pending bit; saturates.
- `stat_cnt`  out  N*CNT_W  per-line dispatch counters; line i occupies bits [i*CNT_W +: CNT_W].

## Operation
- Reset values: `pend`=0, `out_valid`=0, `out_onehot`=0, `drop_cnt`=0, `stat_cnt`=0, FSM=IDLE. `in_ready` is 0 while `rst_n`=0 and 1 otherwise.
- Accept: on each edge with `in_valid`=1, `pend[in_code]` is set.
  - If that bit was already 1 and is not being cleared on the same edge, `drop_cnt` increments, saturating at all-ones.
- Selection: `sel` = one-hot of the highest set bit of `pend`, with the same priority as the encoder (bit N-1 wins).
- FSM has two states, IDLE and ISSUE.
  - IDLE -> ISSUE when `en`=1 and `pend`≠0. On that edge: `out_onehot`<=`sel`, `out_valid`<=1, and the `sel` bit of `pend` is cleared.
  - ISSUE, `out_ready`=0: hold. `out_onehot` stays stable; new arrivals only update `pend`.
  - ISSUE, `out_ready`=1, `en`=1, `pend`≠0: back-to-back. Load the next `sel`, clear its pend bit, stay in ISSUE.
  - ISSUE, `out_ready`=1, otherwise: `out_valid`<=0, `out_onehot`<=0, go to IDLE.
- Set/clear collision: if an arriving code targets the bit being cleared on the same edge, the set wins. The bit stays pending, is not counted as a drop, and is dispatched again later.
- `en`=0 never aborts an in-flight dispatch. It only stops new loads. Accepts continue while `en`=0.
- Asynchronous reset mid-dispatch drops all pending and in-flight state immediately.

## Timing
- Latency: `in_valid` sampled at edge k -> `pend` bit visible after edge k -> `out_valid` high after edge k+1, assuming IDLE and `en`=1.
- Throughput: one dispatch per cycle while `out_ready`=1 and `pend`≠0.
- All outputs are registered; no combinational path from any input to any output.

## Configuration
- Macro: `CODE_DISPATCHER_STATS_EN`.
- Defined: on each completed handshake (`out_valid`&`out_ready`), `stat_cnt` slice i increments for the dispatched line i, saturating at all-ones.
- Undefined: counter logic is not built and `stat_cnt` is tied to 0. The port list is the same either way.

## Structure
- Shared package `code_dispatch_pkg`: `CODE_W` default, FSM state enum (`ST_IDLE`, `ST_ISSUE`), and a `N_LINES(code_w)` helper constant.
- One sub-module, `msb_onehot_sel`: combinational highest-set-bit one-hot selector, parameterised by N. The top level holds the pend register, FSM and counters.

## Test plan
- Reset, then `in_code`=2 pulsed for 1 cycle with `out_ready`=1 -> `out_onehot`=0100 for exactly 1 cycle, 2 cycles after the pulse; `pend` returns to 0000.
- Codes 0, 1, 3 on consecutive cycles, `en`=0, then `en`=1 with `out_ready`=1 -> `pend` reads 1011, then dispatches 1000, 0010, 0001 on consecutive cycles.
- Code 3 twice while dispatch is stalled (`out_ready`=0) -> `pend`=1000 and `drop_cnt`=1. After release, line 3 is dispatched once more.
- Arrival of code 1 on the same edge its pend bit is cleared -> 0010 is dispatched twice and `drop_cnt` stays 0.
- `rst_n` pulled low while `out_valid`=1 and `pend`=0110 -> all outputs are 0 immediately, and no dispatch occurs after release.
- With `CODE_DISPATCHER_STATS_EN`: 300 dispatches of line 0 -> slice 0 of `stat_cnt` = 255 and the other slices = 0. Without the macro, `stat_cnt` = 0 throughout.

Source files
------------

// File: rtl/code_dispatch_pkg.sv
// rtl/code_dispatch_pkg.sv - shared constants, FSM states and helpers for code_dispatcher
//
// Purpose: default code width, dispatch FSM state enum and the line-count helper.
// Ports: none (package).

package code_dispatch_pkg;

    localparam int CODE_W_DEF = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    // Number of one-hot service lines for a given code width.
    function automatic int N_LINES(input int code_w);
        return 1 << code_w;
    endfunction

endpackage

// File: rtl/code_dispatcher_msb_onehot_sel.sv
// rtl/code_dispatcher_msb_onehot_sel.sv - combinational highest-set-bit one-hot selector
//
// Purpose: picks the highest set bit of req (bit N-1 has priority) as a one-hot vector.
// Ports:
//   req  in   N  request bitmap
//   sel  out  N  one-hot of the highest set bit of req, zero when req is zero
//   any  out  1  req has at least one bit set

module msb_onehot_sel #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] sel,
    output logic         any
);

    // Ascending scan: the last (highest) set bit overwrites lower picks.
    always_comb begin
        sel = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                sel    = '0;
                sel[i] = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/code_dispatcher.sv
// rtl/code_dispatcher.sv - pending-bitmap dispatcher for priority-encoder codes
//
// Purpose: latches incoming codes into a pending bitmap and dispatches pending lines
// one at a time, highest index first, as one-hot over a valid/ready handshake.
// Optional per-line dispatch statistics are built when CODE_DISPATCHER_STATS_EN is defined.
// Ports:
//   clk, rst_n            clock (rising edge) and asynchronous active-low reset
//   in_valid, in_code     incoming code; in_ready is 1 whenever out of reset
//   en                    dispatch enable; 0 blocks new loads, never aborts one in flight
//   out_valid, out_onehot dispatch in flight and its one-hot line
//   out_ready             consumer accepts the dispatch
//   pend                  pending bitmap
//   drop_cnt              saturating count of codes merged into an already-pending bit
//   stat_cnt              per-line saturating dispatch counters, line i at [i*CNT_W +: CNT_W]

module code_dispatcher
    import code_dispatch_pkg::*;
#(
    parameter  int CODE_W = CODE_W_DEF,
    parameter  int CNT_W  = 8,
    localparam int N      = N_LINES(CODE_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [CODE_W-1:0] in_code,
    output logic              in_ready,
    input  logic              en,
    output logic              out_valid,
    output logic [N-1:0]      out_onehot,
    input  logic              out_ready,
    output logic [N-1:0]      pend,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic [N*CNT_W-1:0] stat_cnt
);

    state_t       state;
    logic [N-1:0] sel;
    logic         pend_any;
    logic         free;
    logic         load;
    logic [N-1:0] one_n;
    logic [N-1:0] set_mask;
    logic [N-1:0] clr_mask;
    logic         drop_hit;

    msb_onehot_sel #(.N(N)) u_sel (
        .req (pend),
        .sel (sel),
        .any (pend_any)
    );

    // The output slot is free when nothing is in flight or the current one is accepted.
    assign free     = (state == ST_IDLE) || out_ready;
    assign load     = free && en && pend_any;
    assign one_n    = {{(N-1){1'b0}}, 1'b1};
    assign set_mask = in_valid ? (one_n << in_code) : '0;
    assign clr_mask = load ? sel : '0;
    // A set landing on the bit being cleared is a re-request, not a merge.
    assign drop_hit = |(set_mask & pend & ~clr_mask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_onehot <= '0;
            pend       <= '0;
            drop_cnt   <= '0;
        end else begin
            in_ready <= 1'b1;
            pend     <= (pend & ~clr_mask) | set_mask;
            if (drop_hit && (drop_cnt != {CNT_W{1'b1}})) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
            if (free) begin
                if (load) begin
                    state      <= ST_ISSUE;
                    out_valid  <= 1'b1;
                    out_onehot <= sel;
                end else begin
                    state      <= ST_IDLE;
                    out_valid  <= 1'b0;
                    out_onehot <= '0;
                end
            end
        end
    end

`ifdef CODE_DISPATCHER_STATS_EN
    for (genvar i = 0; i < N; i++) begin : g_stat
        logic [CNT_W-1:0] cnt;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt <= '0;
            end else if (out_valid && out_ready && out_onehot[i] && (cnt != {CNT_W{1'b1}})) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
        assign stat_cnt[i*CNT_W +: CNT_W] = cnt;
    end
`else
    assign stat_cnt = '0;
`endif

endmodule

// File: tb/tb_code_dispatcher.sv
// tb/tb_code_dispatcher.sv - self-checking testbench for code_dispatcher

module tb_code_dispatcher;

    localparam int CODE_W = 2;
    localparam int N      = 4;
    localparam int CNT_W  = 8;
    localparam int SAT    = 255;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic [CODE_W-1:0] in_code;
    logic              in_ready;
    logic              en;
    logic              out_valid;
    logic [N-1:0]      out_onehot;
    logic              out_ready;
    logic [N-1:0]      pend;
    logic [CNT_W-1:0]  drop_cnt;
    logic [N*CNT_W-1:0] stat_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: pending set, in-flight line (or none), counters.
    int m_pend [N];
    bit m_busy;
    int m_line;
    int m_drop;
    int m_stat [N];

    code_dispatcher #(.CODE_W(CODE_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_code    (in_code),
        .in_ready   (in_ready),
        .en         (en),
        .out_valid  (out_valid),
        .out_onehot (out_onehot),
        .out_ready  (out_ready),
        .pend       (pend),
        .drop_cnt   (drop_cnt),
        .stat_cnt   (stat_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 0;
            m_stat[i] = 0;
        end
        m_busy = 1'b0;
        m_line = -1;
        m_drop = 0;
    endtask

    task automatic model_edge(input bit iv, input int ic, input bit e, input bit rdy);
        int  pick;
        bit  slot_free;
        pick      = -1;
        slot_free = !m_busy || rdy;
`ifdef CODE_DISPATCHER_STATS_EN
        if (m_busy && rdy && m_stat[m_line] < SAT) m_stat[m_line]++;
`endif
        for (int i = 0; i < N; i++) if (m_pend[i] != 0) pick = i;
        if (!(e && slot_free)) pick = -1;
        if (slot_free) begin
            m_busy = (pick >= 0);
            m_line = pick;
        end
        if (iv && m_pend[ic] != 0 && ic != pick && m_drop < SAT) m_drop++;
        if (pick >= 0) m_pend[pick] = 0;
        if (iv) m_pend[ic] = 1;
    endtask

    function automatic logic [N-1:0] m_pend_vec();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = (m_pend[i] != 0);
        return v;
    endfunction

    function automatic logic [N-1:0] m_onehot_vec();
        logic [N-1:0] v;
        v = '0;
        if (m_busy) v[m_line] = 1'b1;
        return v;
    endfunction

    function automatic logic [N*CNT_W-1:0] m_stat_vec();
        logic [N*CNT_W-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i*CNT_W +: CNT_W] = CNT_W'(m_stat[i]);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_code   = '0;
        en        = 1'b0;
        out_ready = 1'b0;
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; in_code = '0; en = 1'b1; out_ready = 1'b1;
        #3;
        n_tests++;
        if ({in_ready, out_valid, out_onehot, pend, drop_cnt, stat_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: rdy=%b ov=%b oh=%b pend=%b drop=%0d stat=%h, required all 0",
                     in_ready, out_valid, out_onehot, pend, drop_cnt, stat_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL in_ready_after_reset: got %b, required 1", in_ready);
        end
    endtask

    task automatic test_single();
        do_reset();
        en = 1'b1; out_ready = 1'b1;
        in_valid = 1'b1; in_code = 2'd2;
        tick();
        in_valid = 1'b0;
        n_tests++;
        if (pend !== 4'b0100 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pend: pend=%b ov=%b, required 0100 0", pend, out_valid);
        end
        tick();
        n_tests++;
        if (out_onehot !== 4'b0100 || out_valid !== 1'b1 || pend !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_issue: oh=%b ov=%b pend=%b, required 0100 1 0000", out_onehot, out_valid, pend);
        end
        tick();
        n_tests++;
        if (out_onehot !== 4'b0000 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: oh=%b ov=%b, required 0000 0", out_onehot, out_valid);
        end
    endtask

    task automatic test_priority();
        logic [N-1:0] exp_seq [4];
        exp_seq[0] = 4'b1000; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0001; exp_seq[3] = 4'b0000;
        do_reset();
        en = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1;
        in_code = 2'd0; tick();
        in_code = 2'd1; tick();
        in_code = 2'd3; tick();
        in_valid = 1'b0;
        n_tests++;
        if (pend !== 4'b1011 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_pend: pend=%b ov=%b, required 1011 0", pend, out_valid);
        end
        en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_tests++;
            if (out_onehot !== exp_seq[k]) begin
                n_fail++;
                $display("FAIL prio_seq%0d: oh=%b, required %b", k, out_onehot, exp_seq[k]);
            end
        end
    endtask

    task automatic test_drop();
        do_reset();
        en = 1'b1; out_ready = 1'b0;
        in_valid = 1'b1; in_code = 2'd0; tick();
        in_valid = 1'b0; tick();
        in_valid = 1'b1; in_code = 2'd3; tick(); tick();
        in_valid = 1'b0;
        n_tests++;
        if (pend !== 4'b1000 || drop_cnt !== 8'd1 || out_onehot !== 4'b0001) begin
            n_fail++;
            $display("FAIL drop_stall: pend=%b drop=%0d oh=%b, required 1000 1 0001", pend, drop_cnt, out_onehot);
        end
        out_ready = 1'b1;
        tick();
        n_tests++;
        if (out_onehot !== 4'b1000 || pend !== 4'b0000) begin
            n_fail++;
            $display("FAIL drop_release: oh=%b pend=%b, required 1000 0000", out_onehot, pend);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b0 || drop_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL drop_after: ov=%b drop=%0d, required 0 1", out_valid, drop_cnt);
        end
    endtask

    task automatic test_collision();
        do_reset();
        en = 1'b1; out_ready = 1'b1;
        in_valid = 1'b1; in_code = 2'd1; tick();
        tick();
        in_valid = 1'b0;
        n_tests++;
        if (out_onehot !== 4'b0010 || pend !== 4'b0010 || drop_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL coll_first: oh=%b pend=%b drop=%0d, required 0010 0010 0", out_onehot, pend, drop_cnt);
        end
        tick();
        n_tests++;
        if (out_onehot !== 4'b0010 || pend !== 4'b0000) begin
            n_fail++;
            $display("FAIL coll_second: oh=%b pend=%b, required 0010 0000", out_onehot, pend);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b0 || drop_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL coll_end: ov=%b drop=%0d, required 0 0", out_valid, drop_cnt);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        en = 1'b0; out_ready = 1'b0;
        in_valid = 1'b1;
        in_code = 2'd3; tick();
        in_code = 2'd1; tick();
        in_code = 2'd2; tick();
        in_valid = 1'b0; en = 1'b1;
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_onehot !== 4'b1000 || pend !== 4'b0110) begin
            n_fail++;
            $display("FAIL rstmid_setup: ov=%b oh=%b pend=%b, required 1 1000 0110", out_valid, out_onehot, pend);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({in_ready, out_valid, out_onehot, pend, drop_cnt, stat_cnt} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_async: rdy=%b ov=%b oh=%b pend=%b drop=%0d, required all 0",
                     in_ready, out_valid, out_onehot, pend, drop_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_tests++;
            if (out_valid !== 1'b0 || pend !== 4'b0000) begin
                n_fail++;
                $display("FAIL rstmid_quiet%0d: ov=%b pend=%b, required 0 0000", k, out_valid, pend);
            end
        end
        model_reset();
    endtask

    task automatic test_stats();
        logic [N*CNT_W-1:0] exp_stat;
        do_reset();
        en = 1'b1; out_ready = 1'b1;
        in_valid = 1'b1; in_code = 2'd0;
        for (int k = 0; k < 305; k++) tick();
        in_valid = 1'b0;
        tick(); tick();
`ifdef CODE_DISPATCHER_STATS_EN
        exp_stat = {8'd0, 8'd0, 8'd0, 8'd255};
`else
        exp_stat = '0;
`endif
        n_tests++;
        if (stat_cnt !== exp_stat) begin
            n_fail++;
            $display("FAIL stats_line0: stat=%h, required %h", stat_cnt, exp_stat);
        end
    endtask

    task automatic test_random();
        int rdy_pct;
        int v_pct;
        do_reset();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (cyc % 200 == 0) begin
                rdy_pct = $urandom_range(10, 95);
                v_pct   = $urandom_range(10, 90);
            end
            in_valid  = ($urandom_range(0, 99) < v_pct);
            in_code   = CODE_W'($urandom_range(0, N-1));
            en        = ($urandom_range(0, 99) < 80);
            out_ready = ($urandom_range(0, 99) < rdy_pct);
            model_edge(in_valid, int'(in_code), en, out_ready);
            tick();
            n_tests++;
            if (out_valid !== m_busy || out_onehot !== m_onehot_vec() || pend !== m_pend_vec() ||
                drop_cnt !== CNT_W'(m_drop) || stat_cnt !== m_stat_vec() || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL random_cyc%0d: ov=%b oh=%b pend=%b drop=%0d stat=%h, required %b %b %b %0d %h",
                         cyc, out_valid, out_onehot, pend, drop_cnt, stat_cnt,
                         m_busy, m_onehot_vec(), m_pend_vec(), m_drop, m_stat_vec());
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_priority();
        test_drop();
        test_collision();
        test_reset_mid();
        test_stats();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
